// File: rtl/vga_timing_dual_if.sv
// vga_timing_dual_if: bundle between the dual-mode VGA timing generator and its consumers.
//   master (generator): receives en, mode_req; drives mode_act, hcount, vcount, hblnk,
//                       vblnk, hsync, vsync, frame_start, line_start.
//   slave  (consumer/driver side): the mirror image.
interface vga_timing_dual_if #(
    parameter int unsigned CNT_W = 11
);
    logic             en;
    logic             mode_req;
    logic             mode_act;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
    logic             frame_start;
    logic             line_start;

    modport master (
        input  en, mode_req,
        output mode_act, hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start, line_start
    );

    modport slave (
        output en, mode_req,
        input  mode_act, hcount, vcount, hblnk, vblnk, hsync, vsync, frame_start, line_start
    );
endinterface

// File: rtl/vga_timing_dual.sv
// vga_timing_dual: VGA timing generator with two parameter-defined modes (A = 0, B = 1).
// Mode requests are sampled on the last pixel of a frame only, so a switch always lands
// on a frame boundary. All outputs are registered and describe the presented counts.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset
//   bus  - vga_timing_dual_if.master: en, mode_req in; counts, blanking, sync, pulses out
module vga_timing_dual #(
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned A_H_TOTAL  = 1056,
    parameter int unsigned A_H_BLANK  = 800,
    parameter int unsigned A_H_SYNC_S = 840,
    parameter int unsigned A_H_SYNC_E = 968,
    parameter int unsigned A_V_TOTAL  = 628,
    parameter int unsigned A_V_BLANK  = 600,
    parameter int unsigned A_V_SYNC_S = 601,
    parameter int unsigned A_V_SYNC_E = 605,
    parameter bit          A_HS_POL   = 1'b1,
    parameter bit          A_VS_POL   = 1'b1,
    parameter int unsigned B_H_TOTAL  = 800,
    parameter int unsigned B_H_BLANK  = 640,
    parameter int unsigned B_H_SYNC_S = 656,
    parameter int unsigned B_H_SYNC_E = 752,
    parameter int unsigned B_V_TOTAL  = 525,
    parameter int unsigned B_V_BLANK  = 480,
    parameter int unsigned B_V_SYNC_S = 490,
    parameter int unsigned B_V_SYNC_E = 492,
    parameter bit          B_HS_POL   = 1'b0,
    parameter bit          B_VS_POL   = 1'b0
) (
    input logic              clk,
    input logic              rst,
    vga_timing_dual_if.master bus
);
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             mode_q, mode_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_q, frame_d;
    logic             line_q, line_d;

    // Last count of the currently active mode
    logic [CNT_W-1:0] h_last, v_last;

    // Decoration thresholds of the mode that owns the next-state counts
    int unsigned      h_blank, h_sync_s, h_sync_e;
    int unsigned      v_blank, v_sync_s, v_sync_e;
    logic             hs_pol, vs_pol;
    logic             in_hs, in_vs;

    always_comb begin
        h_last   = mode_q ? CNT_W'(B_H_TOTAL - 1) : CNT_W'(A_H_TOTAL - 1);
        v_last   = mode_q ? CNT_W'(B_V_TOTAL - 1) : CNT_W'(A_V_TOTAL - 1);

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        mode_d   = mode_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;

        if (bus.en) begin
            if (hcount_q == h_last) begin
                hcount_d = '0;
                line_d   = 1'b1;
                if (vcount_q == v_last) begin
                    vcount_d = '0;
                    frame_d  = 1'b1;
                    // Only the request seen on the last pixel of the frame matters
                    mode_d   = bus.mode_req;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Flags use the mode that will be active alongside the next counts, so the
        // first pixel of a new frame already carries the new mode's polarity.
        if (mode_d) begin
            h_blank  = B_H_BLANK;
            h_sync_s = B_H_SYNC_S;
            h_sync_e = B_H_SYNC_E;
            v_blank  = B_V_BLANK;
            v_sync_s = B_V_SYNC_S;
            v_sync_e = B_V_SYNC_E;
            hs_pol   = B_HS_POL;
            vs_pol   = B_VS_POL;
        end else begin
            h_blank  = A_H_BLANK;
            h_sync_s = A_H_SYNC_S;
            h_sync_e = A_H_SYNC_E;
            v_blank  = A_V_BLANK;
            v_sync_s = A_V_SYNC_S;
            v_sync_e = A_V_SYNC_E;
            hs_pol   = A_HS_POL;
            vs_pol   = A_VS_POL;
        end

        in_hs   = (32'(hcount_d) >= h_sync_s) && (32'(hcount_d) < h_sync_e);
        in_vs   = (32'(vcount_d) >= v_sync_s) && (32'(vcount_d) < v_sync_e);
        hblnk_d = 32'(hcount_d) >= h_blank;
        vblnk_d = 32'(vcount_d) >= v_blank;
        hsync_d = hs_pol ? in_hs : !in_hs;
        vsync_d = vs_pol ? in_vs : !in_vs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            mode_q   <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= ~A_HS_POL;
            vsync_q  <= ~A_VS_POL;
            frame_q  <= 1'b0;
            line_q   <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            mode_q   <= mode_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            frame_q  <= frame_d;
            line_q   <= line_d;
        end
    end

    assign bus.mode_act    = mode_q;
    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.hblnk       = hblnk_q;
    assign bus.vblnk       = vblnk_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_q;
    assign bus.line_start  = line_q;
endmodule

// File: tb/tb_vga_timing_dual.sv
// tb_vga_timing_dual: bench for vga_timing_dual using two small video modes so that whole
// frames fit in a short run. A pixel-index model (position = index within the frame)
// predicts every output on every cycle; literal checks pin periods and windows.
module tb_vga_timing_dual;
    localparam int unsigned W   = 6;
    localparam int unsigned AHT = 20, AHB = 14, AHS = 15, AHE = 18;
    localparam int unsigned AVT = 12, AVB = 9,  AVS = 10, AVE = 11;
    localparam int unsigned BHT = 16, BHB = 10, BHS = 11, BHE = 13;
    localparam int unsigned BVT = 10, BVB = 8,  BVS = 8,  BVE = 9;
    localparam bit AHP = 1'b1, AVP = 1'b1, BHP = 1'b0, BVP = 1'b0;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_on = 1'b0;

    vga_timing_dual_if #(.CNT_W(W)) bus ();

    vga_timing_dual #(
        .CNT_W(W),
        .A_H_TOTAL(AHT), .A_H_BLANK(AHB), .A_H_SYNC_S(AHS), .A_H_SYNC_E(AHE),
        .A_V_TOTAL(AVT), .A_V_BLANK(AVB), .A_V_SYNC_S(AVS), .A_V_SYNC_E(AVE),
        .A_HS_POL(AHP), .A_VS_POL(AVP),
        .B_H_TOTAL(BHT), .B_H_BLANK(BHB), .B_H_SYNC_S(BHS), .B_H_SYNC_E(BHE),
        .B_V_TOTAL(BVT), .B_V_BLANK(BVB), .B_V_SYNC_S(BVS), .B_V_SYNC_E(BVE),
        .B_HS_POL(BHP), .B_VS_POL(BVP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_p = 0;     // pixel index within the current frame
    bit m_mode = 0;
    bit m_fs = 0;
    bit m_ls = 0;

    function automatic int unsigned ht(bit m);
        return m ? BHT : AHT;
    endfunction

    function automatic int unsigned vt(bit m);
        return m ? BVT : AVT;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p    <= 0;
            m_mode <= 1'b0;
            m_fs   <= 1'b0;
            m_ls   <= 1'b0;
        end else if (bus.en) begin
            if (m_p == int'(ht(m_mode) * vt(m_mode)) - 1) begin
                m_p    <= 0;
                m_mode <= bus.mode_req;
                m_fs   <= 1'b1;
                m_ls   <= 1'b1;
            end else begin
                m_p  <= m_p + 1;
                m_fs <= 1'b0;
                m_ls <= ((m_p + 1) % int'(ht(m_mode))) == 0;
            end
        end else begin
            m_fs <= 1'b0;
            m_ls <= 1'b0;
        end
    end

    function automatic logic [18:0] model_vec();
        int unsigned h, v;
        bit hb, vb, hs, vs;
        h  = int'(m_p) % ht(m_mode);
        v  = int'(m_p) / ht(m_mode);
        hb = h >= (m_mode ? BHB : AHB);
        vb = v >= (m_mode ? BVB : AVB);
        hs = ((h >= (m_mode ? BHS : AHS)) && (h < (m_mode ? BHE : AHE))) == (m_mode ? BHP : AHP);
        vs = ((v >= (m_mode ? BVS : AVS)) && (v < (m_mode ? BVE : AVE))) == (m_mode ? BVP : AVP);
        return {m_mode, 6'(h), 6'(v), hb, vb, hs, vs, m_fs, m_ls};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus.mode_act, bus.hcount, bus.vcount, bus.hblnk, bus.vblnk,
                bus.hsync, bus.vsync, bus.frame_start, bus.line_start};
    endfunction

    always @(negedge clk) begin
        if (cmp_on) chk("cycle_vec", int'(dut_vec()), int'(model_vec()));
    end

    // ---------------- helpers ----------------
    task automatic wait_hv(input int h, input int v);
        int k = 0;
        while (!(int'(bus.hcount) == h && (v < 0 || int'(bus.vcount) == v)) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("timeout_hv", 1, 0);
    endtask

    function automatic bit pulse(input bit frame);
        return frame ? bus.frame_start : bus.line_start;
    endfunction

    task automatic wait_pulse(input bit frame);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pulse(frame) && k < 2000);
        if (k >= 2000) chk("timeout_pulse", 1, 0);
    endtask

    task automatic measure(input bit frame, output int n);
        wait_pulse(frame);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pulse(frame) && n < 2000);
    endtask

    task automatic scan_line(input int len, output int rise, output int hs_hi);
        rise  = -1;
        hs_hi = 0;
        wait_hv(0, -1);
        for (int i = 0; i < len; i++) begin
            if (bus.hblnk && rise < 0) rise = int'(bus.hcount);
            if (bus.hsync) hs_hi++;
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, rise, hs_hi;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.mode_req = 1'b0;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        @(negedge clk);
        chk("rst_hcount", int'(bus.hcount), 0);
        chk("rst_vcount", int'(bus.vcount), 0);
        chk("rst_hsync", int'(bus.hsync), 0);
        chk("rst_vsync", int'(bus.vsync), 0);
        chk("rst_mode", int'(bus.mode_act), 0);
        rst    = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        chk("first_hcount", int'(bus.hcount), 1);
        chk("first_ls", int'(bus.line_start), 0);
        chk("first_fs", int'(bus.frame_start), 0);

        // Mode A line and frame
        measure(1'b0, n);
        chk("line_period_A", n, 20);
        scan_line(int'(AHT), rise, hs_hi);
        chk("hblnk_rise_A", rise, 14);
        chk("hsync_hi_A", hs_hi, 3);
        measure(1'b1, n);
        chk("frame_period_A", n, 240);

        // Mid-frame request that is withdrawn before the last pixel
        wait_hv(3, 5);
        bus.mode_req = 1'b1;
        repeat (7) @(negedge clk);
        bus.mode_req = 1'b0;
        wait_pulse(1'b1);
        chk("mode_pulse_ignored", int'(bus.mode_act), 0);

        // Real switch to mode B
        wait_hv(0, 6);
        bus.mode_req = 1'b1;
        chk("mode_before_wrap", int'(bus.mode_act), 0);
        wait_pulse(1'b1);
        chk("mode_after_switch", int'(bus.mode_act), 1);
        chk("hsync_idle_B", int'(bus.hsync), 1);
        chk("vsync_idle_B", int'(bus.vsync), 1);
        scan_line(int'(BHT), rise, hs_hi);
        chk("hblnk_rise_B", rise, 10);
        chk("hsync_hi_B", hs_hi, 14);
        measure(1'b1, n);
        chk("frame_period_B", n, 160);

        // Enable hold
        wait_hv(7, -1);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_hcount", int'(bus.hcount), 7);
            chk("hold_ls", int'(bus.line_start), 0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        chk("resume_hcount", int'(bus.hcount), 8);

        // Randomised enable gaps and mode requests
        for (int i = 0; i < 3000; i++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) bus.mode_req = ~bus.mode_req;
            @(negedge clk);
        end

        // Asynchronous reset while in mode B
        bus.en       = 1'b1;
        bus.mode_req = 1'b1;
        wait_pulse(1'b1);
        chk("mode_B_before_rst", int'(bus.mode_act), 1);
        wait_hv(5, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_mode", int'(bus.mode_act), 0);
        chk("arst_hcount", int'(bus.hcount), 0);
        chk("arst_vcount", int'(bus.vcount), 0);
        chk("arst_hsync", int'(bus.hsync), 0);
        chk("arst_vsync", int'(bus.vsync), 0);
        bus.mode_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_hcount", int'(bus.hcount), 1);
        chk("restart_mode", int'(bus.mode_act), 0);
        repeat (300) @(negedge clk);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
